// File: rtl/mul_div_issue_queue.sv
// rtl/mul_div_issue_queue.sv - collapsing out-of-order issue queue feeding the mul and div units
module mul_div_issue_queue #(
  parameter int                  DEPTH       = 4,
  parameter int                  WORD_WIDTH  = 32,
  parameter int                  OP_WIDTH    = 5,
  parameter int                  PTAG_W      = 6,
  parameter int                  WB_PORTS    = 2,
  parameter logic [OP_WIDTH-1:0] ALU_OP_DIV  = OP_WIDTH'(12),
  parameter logic [OP_WIDTH-1:0] ALU_OP_DIVU = OP_WIDTH'(13),
  parameter logic [OP_WIDTH-1:0] ALU_OP_REM  = OP_WIDTH'(14),
  parameter logic [OP_WIDTH-1:0] ALU_OP_REMU = OP_WIDTH'(15)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           dispatch_en,
  input  logic [OP_WIDTH-1:0]            dispatch_op,
  input  logic                           dispatch_rs1_ready,
  input  logic                           dispatch_rs2_ready,
  input  logic [PTAG_W-1:0]              dispatch_rs1_Ptag,
  input  logic [PTAG_W-1:0]              dispatch_rs2_Ptag,
  input  logic [WORD_WIDTH-1:0]          dispatch_rs1_value,
  input  logic [WORD_WIDTH-1:0]          dispatch_rs2_value,
  input  logic [PTAG_W-1:0]              dispatch_Pdst,
  output logic                           queue_full,
  input  logic [WB_PORTS-1:0]            wb_valid,
  input  logic [WB_PORTS*PTAG_W-1:0]     wb_Paddr,
  input  logic [WB_PORTS*WORD_WIDTH-1:0] wb_value,
  input  logic                           div_ready,
  output logic                           mul_div_issue_en,
  output logic [OP_WIDTH-1:0]            mul_div_issue_queue_op,
  output logic [WORD_WIDTH-1:0]          mul_div_issue_queue_rs1_value,
  output logic [WORD_WIDTH-1:0]          mul_div_issue_queue_rs2_value,
  output logic [PTAG_W-1:0]              mul_div_issue_queue_Pdst
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                  valid;
    logic [OP_WIDTH-1:0]   op;
    logic                  rs1_rdy;
    logic [PTAG_W-1:0]     rs1_tag;
    logic [WORD_WIDTH-1:0] rs1_val;
    logic                  rs2_rdy;
    logic [PTAG_W-1:0]     rs2_tag;
    logic [WORD_WIDTH-1:0] rs2_val;
    logic [PTAG_W-1:0]     pdst;
  } entry_t;

  // Returns {rdy, val} after snooping the broadcast ports; lowest matching port wins.
  function automatic logic [WORD_WIDTH:0] wake(
    input logic                           rdy,
    input logic [PTAG_W-1:0]              tag,
    input logic [WORD_WIDTH-1:0]          val,
    input logic [WB_PORTS-1:0]            v,
    input logic [WB_PORTS*PTAG_W-1:0]     t,
    input logic [WB_PORTS*WORD_WIDTH-1:0] d
  );
    logic [WORD_WIDTH:0] r;
    r = {rdy, val};
    for (int p = WB_PORTS - 1; p >= 0; p--) begin
      if (!rdy && v[p] && (t[p*PTAG_W +: PTAG_W] == tag)) begin
        r = {1'b1, d[p*WORD_WIDTH +: WORD_WIDTH]};
      end
    end
    return r;
  endfunction

  function automatic logic is_div(input logic [OP_WIDTH-1:0] op);
    return (op == ALU_OP_DIV) || (op == ALU_OP_DIVU) || (op == ALU_OP_REM) || (op == ALU_OP_REMU);
  endfunction

  entry_t                ent_q [DEPTH];
  entry_t                ent_d [DEPTH];
  entry_t                woke  [DEPTH+1];
  entry_t                sel_ent;
  entry_t                new_ent;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  div_block_q, div_block_d;
  logic                  found, issue_go, accept;
  int                    sel, disp_idx;

  logic                  issue_en_q;
  logic [OP_WIDTH-1:0]   issue_op_q;
  logic [WORD_WIDTH-1:0] issue_rs1_q, issue_rs2_q;
  logic [PTAG_W-1:0]     issue_pdst_q;

  assign queue_full = (count_q == CNT_W'(DEPTH));

  always_comb begin
    // The extra all-zero slot lets the top entry shift in an empty record.
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent_q[i];
      {woke[i].rs1_rdy, woke[i].rs1_val} =
        wake(ent_q[i].rs1_rdy, ent_q[i].rs1_tag, ent_q[i].rs1_val, wb_valid, wb_Paddr, wb_value);
      {woke[i].rs2_rdy, woke[i].rs2_val} =
        wake(ent_q[i].rs2_rdy, ent_q[i].rs2_tag, ent_q[i].rs2_val, wb_valid, wb_Paddr, wb_value);
    end
    woke[DEPTH] = '0;

    found   = 1'b0;
    sel     = 0;
    sel_ent = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy &&
          (!is_div(ent_q[i].op) || (div_ready && !div_block_q))) begin
        found   = 1'b1;
        sel     = i;
        sel_ent = ent_q[i];
      end
    end
    issue_go = found && !flush;
    accept   = dispatch_en && !queue_full && !flush;
    disp_idx = int'(count_q) - (issue_go ? 1 : 0);

    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.op      = dispatch_op;
    new_ent.rs1_tag = dispatch_rs1_Ptag;
    new_ent.rs2_tag = dispatch_rs2_Ptag;
    new_ent.pdst    = dispatch_Pdst;
    {new_ent.rs1_rdy, new_ent.rs1_val} =
      wake(dispatch_rs1_ready, dispatch_rs1_Ptag, dispatch_rs1_value, wb_valid, wb_Paddr, wb_value);
    {new_ent.rs2_rdy, new_ent.rs2_val} =
      wake(dispatch_rs2_ready, dispatch_rs2_Ptag, dispatch_rs2_value, wb_valid, wb_Paddr, wb_value);

    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (issue_go && (i >= sel)) ? woke[i+1] : woke[i];
      if (accept && (i == disp_idx)) ent_d[i] = new_ent;
      if (flush) ent_d[i].valid = 1'b0;
    end

    if (flush) count_d = '0;
    else       count_d = count_q - CNT_W'(issue_go) + CNT_W'(accept);

    // Covers the cycle before the divider drops div_ready after accepting a start.
    div_block_d = issue_go && is_div(sel_ent.op);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q      <= '0;
      div_block_q  <= 1'b0;
      issue_en_q   <= 1'b0;
      issue_op_q   <= '0;
      issue_rs1_q  <= '0;
      issue_rs2_q  <= '0;
      issue_pdst_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q     <= count_d;
      div_block_q <= div_block_d;
      issue_en_q  <= issue_go;
      if (issue_go) begin
        issue_op_q   <= sel_ent.op;
        issue_rs1_q  <= sel_ent.rs1_val;
        issue_rs2_q  <= sel_ent.rs2_val;
        issue_pdst_q <= sel_ent.pdst;
      end
    end
  end

  assign mul_div_issue_en              = issue_en_q;
  assign mul_div_issue_queue_op        = issue_op_q;
  assign mul_div_issue_queue_rs1_value = issue_rs1_q;
  assign mul_div_issue_queue_rs2_value = issue_rs2_q;
  assign mul_div_issue_queue_Pdst      = issue_pdst_q;

endmodule

// File: tb/tb_mul_div_issue_queue.sv
// tb/tb_mul_div_issue_queue.sv - vector, directed and model-checked random bench for mul_div_issue_queue
module tb_mul_div_issue_queue;

  localparam int DEPTH = 4, W = 32, OPW = 5, PW = 6, WBP = 2;
  localparam int OP_MUL = 10, OP_DIV = 12;

  logic             clk = 1'b0;
  logic             rst_n, flush, dispatch_en;
  logic [OPW-1:0]   dispatch_op;
  logic             dispatch_rs1_ready, dispatch_rs2_ready;
  logic [PW-1:0]    dispatch_rs1_Ptag, dispatch_rs2_Ptag, dispatch_Pdst;
  logic [W-1:0]     dispatch_rs1_value, dispatch_rs2_value;
  logic             queue_full;
  logic [WBP-1:0]   wb_valid;
  logic [WBP*PW-1:0] wb_Paddr;
  logic [WBP*W-1:0] wb_value;
  logic             div_ready;
  logic             mul_div_issue_en;
  logic [OPW-1:0]   mul_div_issue_queue_op;
  logic [W-1:0]     mul_div_issue_queue_rs1_value, mul_div_issue_queue_rs2_value;
  logic [PW-1:0]    mul_div_issue_queue_Pdst;

  mul_div_issue_queue #(.DEPTH(DEPTH), .WORD_WIDTH(W), .OP_WIDTH(OPW), .PTAG_W(PW), .WB_PORTS(WBP)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .dispatch_en(dispatch_en), .dispatch_op(dispatch_op),
    .dispatch_rs1_ready(dispatch_rs1_ready), .dispatch_rs2_ready(dispatch_rs2_ready),
    .dispatch_rs1_Ptag(dispatch_rs1_Ptag), .dispatch_rs2_Ptag(dispatch_rs2_Ptag),
    .dispatch_rs1_value(dispatch_rs1_value), .dispatch_rs2_value(dispatch_rs2_value),
    .dispatch_Pdst(dispatch_Pdst), .queue_full(queue_full), .wb_valid(wb_valid),
    .wb_Paddr(wb_Paddr), .wb_value(wb_value), .div_ready(div_ready),
    .mul_div_issue_en(mul_div_issue_en), .mul_div_issue_queue_op(mul_div_issue_queue_op),
    .mul_div_issue_queue_rs1_value(mul_div_issue_queue_rs1_value),
    .mul_div_issue_queue_rs2_value(mul_div_issue_queue_rs2_value),
    .mul_div_issue_queue_Pdst(mul_div_issue_queue_Pdst)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int wt[WBP];
  logic [W-1:0] wd[WBP];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic [1:0] v, input int t0, input logic [W-1:0] d0,
                          input int t1, input logic [W-1:0] d1);
    wb_valid = v; wt[0] = t0; wt[1] = t1; wd[0] = d0; wd[1] = d1;
    wb_Paddr = {PW'(t1), PW'(t0)};
    wb_value = {d1, d0};
  endtask

  task automatic disp(input logic en, input int op, input logic r1, input int t1, input logic [W-1:0] v1,
                      input logic r2, input int t2, input logic [W-1:0] v2, input int pd);
    dispatch_en = en; dispatch_op = OPW'(op);
    dispatch_rs1_ready = r1; dispatch_rs1_Ptag = PW'(t1); dispatch_rs1_value = v1;
    dispatch_rs2_ready = r2; dispatch_rs2_Ptag = PW'(t2); dispatch_rs2_value = v2;
    dispatch_Pdst = PW'(pd);
  endtask

  task automatic idle();
    flush = 1'b0;
    disp(1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 0, 0);
    drive_wb(2'b00, 0, 0, 0, 0);
  endtask

  task automatic exp_issue(input string name, input int pd);
    chk({name, ".en"}, mul_div_issue_en, 1);
    chk({name, ".pdst"}, mul_div_issue_queue_Pdst, pd);
  endtask

  // Reference model: an ordered list of waiting instructions.
  typedef struct {
    int op; bit r1; int t1; logic [W-1:0] v1; bit r2; int t2; logic [W-1:0] v2; int pd;
  } ment_t;
  ment_t mq[$];
  bit m_en, m_blk;
  int m_op, m_pd;
  logic [W-1:0] m_v1, m_v2;

  function automatic bit m_isdiv(input int op);
    return op >= 12 && op <= 15;
  endfunction

  function automatic ment_t m_wake(input ment_t e);
    ment_t r = e;
    for (int p = 0; p < WBP; p++)
      if (!r.r1 && wb_valid[p] && wt[p] == e.t1) begin r.r1 = 1; r.v1 = wd[p]; break; end
    for (int p = 0; p < WBP; p++)
      if (!r.r2 && wb_valid[p] && wt[p] == e.t2) begin r.r2 = 1; r.v2 = wd[p]; break; end
    return r;
  endfunction

  task automatic model_step();
    int sel;
    bit full, nb;
    ment_t e;
    if (flush) begin
      mq.delete(); m_en = 0; m_blk = 0;
      return;
    end
    full = (mq.size() == DEPTH);
    sel = -1;
    foreach (mq[i])
      if (sel < 0 && mq[i].r1 && mq[i].r2 && (!m_isdiv(mq[i].op) || (div_ready && !m_blk))) sel = i;
    nb = 0;
    m_en = (sel >= 0);
    if (sel >= 0) begin
      m_op = mq[sel].op; m_v1 = mq[sel].v1; m_v2 = mq[sel].v2; m_pd = mq[sel].pd;
      nb = m_isdiv(mq[sel].op);
    end
    foreach (mq[i]) mq[i] = m_wake(mq[i]);
    if (sel >= 0) mq.delete(sel);
    if (dispatch_en && !full) begin
      e = '{int'(dispatch_op), dispatch_rs1_ready, int'(dispatch_rs1_Ptag), dispatch_rs1_value,
            dispatch_rs2_ready, int'(dispatch_rs2_Ptag), dispatch_rs2_value, int'(dispatch_Pdst)};
      mq.push_back(m_wake(e));
    end
    m_blk = nb;
  endtask

  typedef struct {
    bit de; int op; bit r1; int t1; int v1; bit r2; int t2; int v2; int pd;
    bit [1:0] wv; int wt0; int wd0; int wt1; int wd1; bit dr;
    bit een; int eop; int ev1; int ev2; int epd;
  } vec_t;
  vec_t vecs[15];

  initial begin
    // de op r1 t1 v1 r2 t2 v2 pd | wv wt0 wd0 wt1 wd1 dr | een eop ev1 ev2 epd
    vecs[0]  = '{1, 10, 1, 0, 7,  1, 0, 6, 5,  2'b00, 0, 0,   0, 0,   1,  0, 0,  0,   0,  0};
    vecs[1]  = '{0, 0,  0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   1,  1, 10, 7,   6,  5};
    vecs[2]  = '{0, 0,  0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   1,  0, 0,  0,   0,  0};
    vecs[3]  = '{1, 12, 1, 0, 20, 0, 9, 0, 3,  2'b00, 0, 0,   0, 0,   1,  0, 0,  0,   0,  0};
    vecs[4]  = '{0, 0,  0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   1,  0, 0,  0,   0,  0};
    vecs[5]  = '{0, 0,  0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   1,  0, 0,  0,   0,  0};
    vecs[6]  = '{0, 0,  0, 0, 0,  0, 0, 0, 0,  2'b10, 0, 0,   9, 3,   1,  0, 0,  0,   0,  0};
    vecs[7]  = '{0, 0,  0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   1,  1, 12, 20,  3,  3};
    vecs[8]  = '{0, 0,  0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   1,  0, 0,  0,   0,  0};
    vecs[9]  = '{1, 12, 1, 0, 21, 0, 9, 0, 8,  2'b10, 0, 0,   9, 44,  1,  0, 0,  0,   0,  0};
    vecs[10] = '{0, 0,  0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   1,  1, 12, 21,  44, 8};
    vecs[11] = '{0, 0,  0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   1,  0, 0,  0,   0,  0};
    vecs[12] = '{1, 10, 0, 4, 0,  1, 0, 2, 11, 2'b11, 4, 100, 4, 200, 1,  0, 0,  0,   0,  0};
    vecs[13] = '{0, 0,  0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   1,  1, 10, 100, 2,  11};
    vecs[14] = '{0, 0,  0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   1,  0, 0,  0,   0,  0};

    rst_n = 1'b0; div_ready = 1'b1;
    idle();
    tick(); tick();
    chk("reset.en", mul_div_issue_en, 0);
    chk("reset.full", queue_full, 0);
    chk("reset.op", mul_div_issue_queue_op, 0);
    chk("reset.rs1", mul_div_issue_queue_rs1_value, 0);
    chk("reset.pdst", mul_div_issue_queue_Pdst, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    foreach (vecs[k]) begin
      disp(vecs[k].de, vecs[k].op, vecs[k].r1, vecs[k].t1, vecs[k].v1,
           vecs[k].r2, vecs[k].t2, vecs[k].v2, vecs[k].pd);
      drive_wb(vecs[k].wv, vecs[k].wt0, vecs[k].wd0, vecs[k].wt1, vecs[k].wd1);
      div_ready = vecs[k].dr;
      tick();
      chk($sformatf("vec%0d.en", k), mul_div_issue_en, vecs[k].een);
      chk($sformatf("vec%0d.full", k), queue_full, 0);
      if (vecs[k].een) begin
        chk($sformatf("vec%0d.op", k), mul_div_issue_queue_op, vecs[k].eop);
        chk($sformatf("vec%0d.rs1", k), mul_div_issue_queue_rs1_value, vecs[k].ev1);
        chk($sformatf("vec%0d.rs2", k), mul_div_issue_queue_rs2_value, vecs[k].ev2);
        chk($sformatf("vec%0d.pdst", k), mul_div_issue_queue_Pdst, vecs[k].epd);
      end
    end
    idle();

    // Fill with DIV, DIV, MUL, MUL all waiting on tag 7, then a dropped 5th dispatch.
    div_ready = 1'b1;
    disp(1, OP_DIV, 0, 7, 0, 1, 0, 1, 1); tick();
    disp(1, OP_DIV, 0, 7, 0, 1, 0, 1, 2); tick();
    disp(1, OP_MUL, 0, 7, 0, 1, 0, 1, 3); tick();
    disp(1, OP_MUL, 0, 7, 0, 1, 0, 1, 4); tick();
    chk("fill.full", queue_full, 1);
    disp(1, OP_MUL, 1, 0, 5, 1, 0, 5, 15); tick();
    chk("fill.full_after_drop", queue_full, 1);
    idle(); drive_wb(2'b01, 7, 50, 0, 0); tick();
    chk("fill.en_wake", mul_div_issue_en, 0);
    idle(); tick();
    exp_issue("fill.div0", 1);
    chk("fill.div0_rs1", mul_div_issue_queue_rs1_value, 50);
    chk("fill.full_after_issue", queue_full, 0);
    div_ready = 1'b0;
    tick(); exp_issue("fill.mul0", 3);
    tick(); exp_issue("fill.mul1", 4);
    tick(); chk("fill.div1_held_a", mul_div_issue_en, 0);
    tick(); chk("fill.div1_held_b", mul_div_issue_en, 0);
    div_ready = 1'b1;
    tick(); exp_issue("fill.div1", 2);
    tick(); chk("fill.drained", mul_div_issue_en, 0);

    // Two ready divides with div_ready held high.
    div_ready = 1'b0;
    disp(1, OP_DIV, 1, 0, 9, 1, 0, 3, 6); tick();
    disp(1, OP_DIV, 1, 0, 8, 1, 0, 2, 7); tick();
    idle(); div_ready = 1'b1;
    tick(); exp_issue("divblk.first", 6);
    tick(); chk("divblk.gap", mul_div_issue_en, 0);
    tick(); exp_issue("divblk.second", 7);
    tick(); chk("divblk.done", mul_div_issue_en, 0);

    // Flush with three waiting entries and a same-cycle dispatch.
    for (int i = 0; i < 3; i++) begin
      disp(1, OP_MUL, 0, 8, 0, 1, 0, 1, 20 + i); tick();
    end
    disp(1, OP_MUL, 1, 0, 1, 1, 0, 1, 12); flush = 1'b1; tick();
    chk("flush.en", mul_div_issue_en, 0);
    chk("flush.full", queue_full, 0);
    idle(); drive_wb(2'b01, 8, 77, 0, 0); tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("flush.empty%0d", i), mul_div_issue_en, 0);
    end

    // Asynchronous reset mid-run with three waiting entries and an issue in flight.
    for (int i = 0; i < 3; i++) begin
      disp(1, OP_MUL, 0, 8, 0, 1, 0, 1, 30 + i); tick();
    end
    disp(1, OP_MUL, 1, 0, 4, 1, 0, 4, 33); tick();
    idle(); tick();
    exp_issue("rst.pre", 33);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.en", mul_div_issue_en, 0);
    chk("rst.full", queue_full, 0);
    chk("rst.pdst", mul_div_issue_queue_Pdst, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    drive_wb(2'b01, 8, 5, 0, 0); tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("rst.empty%0d", i), mul_div_issue_en, 0);
    end

    // Randomised traffic against the reference model.
    rst_n = 1'b0; tick(); tick();
    @(negedge clk); rst_n = 1'b1;
    mq.delete(); m_en = 0; m_blk = 0;
    tick();
    for (int c = 0; c < 600; c++) begin
      flush = ($urandom_range(0, 39) == 0);
      disp($urandom_range(0, 1), $urandom_range(8, 15),
           $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
           $urandom_range(0, 1), $urandom_range(0, 7), $urandom, $urandom_range(0, 63));
      drive_wb(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom, $urandom_range(0, 7), $urandom);
      div_ready = ($urandom_range(0, 9) < 7);
      model_step();
      tick();
      chk($sformatf("rnd%0d.en", c), mul_div_issue_en, m_en);
      chk($sformatf("rnd%0d.full", c), queue_full, (mq.size() == DEPTH));
      if (m_en) begin
        chk($sformatf("rnd%0d.op", c), mul_div_issue_queue_op, m_op);
        chk($sformatf("rnd%0d.rs1", c), mul_div_issue_queue_rs1_value, m_v1);
        chk($sformatf("rnd%0d.rs2", c), mul_div_issue_queue_rs2_value, m_v2);
        chk($sformatf("rnd%0d.pdst", c), mul_div_issue_queue_Pdst, m_pd);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
